dma_job_scheduler: RTL

//  Queues transfer jobs from two requesters (layer controller, weight loader), arbitrates round-robin and sequences the SDRAM<->memory DMA one job at a time.

---
 rtl/dma_job_scheduler_pkg.sv | 33 +++
 rtl/dma_job_scheduler_job_fifo.sv | 54 +++++
 rtl/dma_job_scheduler.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/dma_job_scheduler_pkg.sv
// Shared definitions for the DMA job scheduler: command layout, FSM encodings,
// DMA direction encodings and the FIFO entry format.
package dma_job_scheduler_pkg;

    localparam int CMD_W        = 29;
    localparam int ENTRY_W      = CMD_W + 1;
    localparam int SDRAM_ADDR_W = 8;
    localparam int MEM_ADDR_W   = 6;

    localparam int RW_BIT   = 28;
    localparam int SRC_MSB  = 27;
    localparam int SRC_LSB  = 20;
    localparam int DST_MSB  = 19;
    localparam int DST_LSB  = 12;
    localparam int MEM1_MSB = 11;
    localparam int MEM1_LSB = 6;
    localparam int MEM2_MSB = 5;
    localparam int MEM2_LSB = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    localparam logic DMA_RW_SDRAM_TO_MEM = 1'b0;
    localparam logic DMA_RW_MEM_TO_SDRAM = 1'b1;

    typedef struct packed {
        logic             id;
        logic [CMD_W-1:0] cmd;
    } job_entry_t;

endpackage

// File: rtl/dma_job_scheduler_job_fifo.sv
// Small synchronous job FIFO. Pointers carry one extra wrap bit so full and
// empty are told apart without a separate occupancy counter. The head entry
// is presented combinationally so a pop can use it in the same cycle.
module job_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 30
) (
    input  logic             clk_h,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr[AW-1:0]];

    // Advance read/write pointers; a refused push or an empty pop leaves them alone.
    always_ff @(posedge clk_h or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Write the accepted entry into storage; contents need no reset since the pointers gate them.
    always_ff @(posedge clk_h) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/dma_job_scheduler.sv
// DMA job scheduler: takes jobs from two requesters with round-robin
// arbitration, queues them, and runs the DMA one job at a time with a
// timeout and a short enable-low gap between jobs. Each job ends with a
// single completion pulse tagged with the owning requester.
module dma_job_scheduler
    import dma_job_scheduler_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk_h,
    input  logic                    rst_n,
    input  logic                    req0_valid,
    input  logic [CMD_W-1:0]        req0_cmd,
    output logic                    req0_ready,
    input  logic                    req1_valid,
    input  logic [CMD_W-1:0]        req1_cmd,
    output logic                    req1_ready,
    input  logic                    dma_done,
    output logic                    dma_rw,
    output logic                    dma_enable,
    output logic [SDRAM_ADDR_W-1:0] dma_sdram_src,
    output logic [SDRAM_ADDR_W-1:0] dma_sdram_dst,
    output logic [MEM_ADDR_W-1:0]   dma_mem1_addr,
    output logic [MEM_ADDR_W-1:0]   dma_mem2_addr,
    output logic                    cmpl_valid,
    output logic                    cmpl_id,
    output logic                    cmpl_err,
    output logic                    busy,
    output logic                    err_sticky
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TW-1:0] RUN_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    logic          rr_ptr;
    logic          grant0;
    logic          grant1;
    job_entry_t    push_entry;
    job_entry_t    head_entry;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [1:0]    state;
    logic [TW-1:0] run_cnt;
    logic [GW-1:0] gap_cnt;
    logic          cur_id;
    logic          run_timeout;

    // Grant at most one requester per cycle; a tie goes to the side the pointer favours.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!fifo_full) begin
            if (req0_valid && req1_valid) begin
                grant0 = !rr_ptr;
                grant1 = rr_ptr;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready     = grant0;
    assign req1_ready     = grant1;
    assign push_entry.id  = grant1;
    assign push_entry.cmd = grant1 ? req1_cmd : req0_cmd;

    // Point the arbiter at the side that was not just served.
    always_ff @(posedge clk_h or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (grant0) begin
            rr_ptr <= 1'b1;
        end else if (grant1) begin
            rr_ptr <= 1'b0;
        end
    end

    job_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_job_fifo (
        .clk_h     (clk_h),
        .rst_n     (rst_n),
        .push      (grant0 || grant1),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign fifo_pop    = (state == ST_LOAD);
    assign dma_enable  = (state == ST_RUN);
    assign run_timeout = (run_cnt == RUN_LAST);
    assign busy        = !fifo_empty || (state != ST_IDLE);

    // Job sequencer: load the head job onto the DMA, run it until done or
    // timeout, report the completion, then hold enable low for the gap.
    always_ff @(posedge clk_h or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            run_cnt       <= '0;
            gap_cnt       <= '0;
            cur_id        <= 1'b0;
            dma_rw        <= DMA_RW_SDRAM_TO_MEM;
            dma_sdram_src <= '0;
            dma_sdram_dst <= '0;
            dma_mem1_addr <= '0;
            dma_mem2_addr <= '0;
            cmpl_valid    <= 1'b0;
            cmpl_id       <= 1'b0;
            cmpl_err      <= 1'b0;
            err_sticky    <= 1'b0;
        end else begin
            cmpl_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    dma_rw        <= head_entry.cmd[RW_BIT] ? DMA_RW_MEM_TO_SDRAM
                                                            : DMA_RW_SDRAM_TO_MEM;
                    dma_sdram_src <= head_entry.cmd[SRC_MSB:SRC_LSB];
                    dma_sdram_dst <= head_entry.cmd[DST_MSB:DST_LSB];
                    dma_mem1_addr <= head_entry.cmd[MEM1_MSB:MEM1_LSB];
                    dma_mem2_addr <= head_entry.cmd[MEM2_MSB:MEM2_LSB];
                    cur_id        <= head_entry.id;
                    run_cnt       <= '0;
                    state         <= ST_RUN;
                end
                ST_RUN: begin
                    if (dma_done) begin
                        cmpl_valid <= 1'b1;
                        cmpl_id    <= cur_id;
                        cmpl_err   <= 1'b0;
                        gap_cnt    <= '0;
                        state      <= ST_GAP;
                    end else if (run_timeout) begin
                        cmpl_valid <= 1'b1;
                        cmpl_id    <= cur_id;
                        cmpl_err   <= 1'b1;
                        err_sticky <= 1'b1;
                        gap_cnt    <= '0;
                        state      <= ST_GAP;
                    end else if (run_cnt != '1) begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
